// File: rtl/duty_scan_ctrl.sv
// duty_scan_ctrl: time-multiplexed tach duty measurement.
// One engine visits each enabled tach input in turn, measures one full
// high phase and the following low phase in clock cycles, and stores the
// counts in a per-channel result slot.
// Ports:
//   CLK_I, RST_I          clock, synchronous active-high reset
//   TAC_I[CH_NUM]         tach inputs (already synchronous)
//   START_I, CONT_I       scan request pulse, continuous-scan level
//   CH_EN_I[CH_NUM]       channel enable mask, latched at scan start
//   RD_CH_I               result read index
//   BUSY_O, CH_SEL_O      scan in progress, channel routed to the engine
//   DONE_O                one-cycle pulse at scan completion
//   RD_HIGH_O, RD_LOW_O   stored high/low counts of RD_CH_I
//   RD_STAT_O             {timeout, valid} of RD_CH_I
module duty_scan_ctrl #(
  parameter int          CH_NUM       = 4,
  parameter int          CH_W         = 2,
  parameter int          SETTLE_CLKS  = 2,
  parameter logic [31:0] TIMEOUT_CLKS = 32'd1000000
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [CH_NUM-1:0] TAC_I,
  input  logic              START_I,
  input  logic              CONT_I,
  input  logic [CH_NUM-1:0] CH_EN_I,
  input  logic [CH_W-1:0]   RD_CH_I,
  output logic              BUSY_O,
  output logic [CH_W-1:0]   CH_SEL_O,
  output logic              DONE_O,
  output logic [31:0]       RD_HIGH_O,
  output logic [31:0]       RD_LOW_O,
  output logic [1:0]        RD_STAT_O
);

  typedef enum logic [2:0] {IDLE, SETTLE, SYNC, MEAS_H, MEAS_L, STORE, NEXT} state_t;

  state_t            state, state_nxt;
  logic [CH_NUM-1:0] mask, mask_val;
  logic [CH_W-1:0]   ch_sel, sel_val;
  logic [7:0]        settle_cnt;
  logic [31:0]       tmo_cnt, hi_cnt, lo_cnt;
  logic              tac_prev, done, done_nxt;
  logic              sel_ld, mask_ld, wr_ok, wr_tmo;
  logic [CH_W:0]     lo_en, nx;

  logic [31:0] slot_hi   [CH_NUM];
  logic [31:0] slot_lo   [CH_NUM];
  logic [1:0]  slot_stat [CH_NUM];

  // tac_prev follows whatever channel is routed, so the SETTLE wait also
  // reloads the edge history from the newly selected input.
  logic tac, rise, fall, tmo_hit;
  assign tac     = TAC_I[ch_sel];
  assign rise    = tac & ~tac_prev;
  assign fall    = ~tac & tac_prev;
  assign tmo_hit = (tmo_cnt == TIMEOUT_CLKS - 32'd1);

  // {found, index} of the lowest set bit
  function automatic logic [CH_W:0] lowest(input logic [CH_NUM-1:0] m);
    logic [CH_W:0] r;
    r = '0;
    for (int i = CH_NUM - 1; i >= 0; i--)
      if (m[i]) r = {1'b1, CH_W'(i)};
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above cur
  function automatic logic [CH_W:0] next_above(input logic [CH_NUM-1:0] m,
                                               input logic [CH_W-1:0] cur);
    logic [CH_W:0] r;
    r = '0;
    for (int i = CH_NUM - 1; i >= 0; i--)
      if (m[i] && i > int'(cur)) r = {1'b1, CH_W'(i)};
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign lo_en = lowest(CH_EN_I);
  assign nx    = next_above(mask, ch_sel);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    sel_ld    = 1'b0;
    sel_val   = ch_sel;
    mask_ld   = 1'b0;
    mask_val  = mask;
    wr_ok     = 1'b0;
    wr_tmo    = 1'b0;
    case (state)
      IDLE: if (START_I) begin
        mask_ld  = 1'b1;
        mask_val = CH_EN_I;
        if (lo_en[CH_W]) begin
          state_nxt = SETTLE;
          sel_ld    = 1'b1;
          sel_val   = lo_en[CH_W-1:0];
        end else begin
          done_nxt = 1'b1;
        end
      end
      SETTLE: if (settle_cnt == 8'(SETTLE_CLKS - 1)) state_nxt = SYNC;
      SYNC: begin
        if (tmo_hit) begin wr_tmo = 1'b1; state_nxt = NEXT; end
        else if (rise) state_nxt = MEAS_H;
      end
      MEAS_H: begin
        if (tmo_hit) begin wr_tmo = 1'b1; state_nxt = NEXT; end
        else if (fall) state_nxt = MEAS_L;
      end
      MEAS_L: begin
        if (tmo_hit) begin wr_tmo = 1'b1; state_nxt = NEXT; end
        else if (rise) state_nxt = STORE;
      end
      STORE: begin
        wr_ok     = 1'b1;
        state_nxt = NEXT;
      end
      NEXT: begin
        if (nx[CH_W]) begin
          state_nxt = SETTLE;
          sel_ld    = 1'b1;
          sel_val   = nx[CH_W-1:0];
        end else begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          // CONT_I is only looked at here, so dropping it mid-scan lets
          // the current scan finish.
          if (CONT_I && lo_en[CH_W]) begin
            mask_ld   = 1'b1;
            mask_val  = CH_EN_I;
            state_nxt = SETTLE;
            sel_ld    = 1'b1;
            sel_val   = lo_en[CH_W-1:0];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= IDLE;
      done       <= 1'b0;
      mask       <= '0;
      ch_sel     <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      tac_prev   <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        slot_hi[i]   <= '0;
        slot_lo[i]   <= '0;
        slot_stat[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      done     <= done_nxt;
      tac_prev <= tac;
      if (sel_ld)  ch_sel <= sel_val;
      if (mask_ld) mask   <= mask_val;
      settle_cnt <= (state == SETTLE) ? settle_cnt + 8'd1 : 8'd0;
      // zero outside the measuring states, so counting starts at SYNC entry
      if (state == SYNC || state == MEAS_H || state == MEAS_L)
        tmo_cnt <= sat_inc(tmo_cnt);
      else
        tmo_cnt <= '0;
      // the edge cycle itself is the first sample of the new phase
      if (state == SYNC && rise)       hi_cnt <= 32'd1;
      else if (state == MEAS_H && tac) hi_cnt <= sat_inc(hi_cnt);
      if (state == MEAS_H && fall)      lo_cnt <= 32'd1;
      else if (state == MEAS_L && !tac) lo_cnt <= sat_inc(lo_cnt);
      if (wr_ok) begin
        slot_hi[ch_sel]   <= hi_cnt;
        slot_lo[ch_sel]   <= lo_cnt;
        slot_stat[ch_sel] <= 2'b01;
      end else if (wr_tmo) begin
        slot_hi[ch_sel]   <= '0;
        slot_lo[ch_sel]   <= '0;
        slot_stat[ch_sel] <= 2'b10;
      end
    end
  end

  // Reads come straight from the slot registers, so a same-cycle write
  // is not visible until the following cycle.
  logic rd_ok;
  assign rd_ok     = int'(RD_CH_I) < CH_NUM;
  assign RD_HIGH_O = rd_ok ? slot_hi[RD_CH_I]   : 32'd0;
  assign RD_LOW_O  = rd_ok ? slot_lo[RD_CH_I]   : 32'd0;
  assign RD_STAT_O = rd_ok ? slot_stat[RD_CH_I] : 2'b00;

  assign BUSY_O   = (state != IDLE);
  assign CH_SEL_O = ch_sel;
  assign DONE_O   = done;

endmodule

// File: tb/tb_duty_scan_ctrl.sv
// Directed bench for duty_scan_ctrl (CH_NUM=4, TIMEOUT_CLKS=100).
// Channel k tach runs high 5+k+extra / low 3+k, or is held low via hold_low.
module tb_duty_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  tac = '0;
  logic        start, cont;
  logic [3:0]  ch_en;
  logic [1:0]  rd_ch;
  logic        busy, done;
  logic [1:0]  ch_sel;
  logic [31:0] rd_high, rd_low;
  logic [1:0]  rd_stat;

  int checks = 0;
  int errors = 0;
  int extra = 0;
  logic [3:0] hold_low = '0;
  logic [3:0] vis;
  int dn;

  always #5 clk = ~clk;

  duty_scan_ctrl #(.CH_NUM(4), .CH_W(2), .SETTLE_CLKS(2), .TIMEOUT_CLKS(32'd100)) dut (
    .CLK_I(clk), .RST_I(rst), .TAC_I(tac), .START_I(start), .CONT_I(cont),
    .CH_EN_I(ch_en), .RD_CH_I(rd_ch), .BUSY_O(busy), .CH_SEL_O(ch_sel),
    .DONE_O(done), .RD_HIGH_O(rd_high), .RD_LOW_O(rd_low), .RD_STAT_O(rd_stat)
  );

  // tach generator, updated on the falling edge
  initial begin
    int ph [4];
    int hl, per;
    for (int k = 0; k < 4; k++) ph[k] = 3 * k;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        hl  = 5 + k + extra;
        per = hl + 3 + k;
        ph[k] = ph[k] + 1;
        if (ph[k] >= per) ph[k] = 0;
        tac[k] = !hold_low[k] && (ph[k] < hl);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input int k, input int hi, input int lo, input int st);
    rd_ch = 2'(k);
    #1;
    chk($sformatf("slot%0d_high", k), rd_high, 32'(hi));
    chk($sformatf("slot%0d_low", k), rd_low, 32'(lo));
    chk($sformatf("slot%0d_stat", k), {30'd0, rd_stat}, 32'(st));
  endtask

  task automatic start_scan();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag, output logic [3:0] v);
    bit seen;
    seen = 1'b0;
    v = '0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (busy) v[ch_sel] = 1'b1;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_tac2(input logic lvl);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (tac[2] === lvl) hit = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk("tac2_level_wait", {31'd0, hit}, 32'd1);
  endtask

  task automatic count_dones(input int n);
    dn = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) dn++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; ch_en = '0; rd_ch = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_chsel", {30'd0, ch_sel}, 32'd0);
    chk_slot(0, 0, 0, 0);
    chk_slot(3, 0, 0, 0);

    // full scan, START on the first cycle out of reset
    rst = 1'b0; ch_en = 4'hF;
    start_scan();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_chsel", {30'd0, ch_sel}, 32'd0);
    repeat (5) @(negedge clk);
    ch_en = 4'b0001;
    start_scan();          // ignored while busy
    ch_en = 4'hF;
    chk("ignored_start_busy", {31'd0, busy}, 32'd1);
    wait_done(600, "scan_all", vis);
    chk("scan_all_busy_at_done", {31'd0, busy}, 32'd0);
    chk("scan_all_visited", {28'd0, vis}, 32'hF);
    count_dones(30);
    chk("scan_all_single_done", 32'(dn), 32'd0);
    for (int k = 0; k < 4; k++) chk_slot(k, 5 + k, 3 + k, 1);

    // sparse mask: longer high phase so rewritten slots differ
    extra = 2;
    repeat (20) @(negedge clk);
    ch_en = 4'b0101;
    start_scan();
    wait_done(600, "scan_0101", vis);
    chk("scan_0101_visited", {28'd0, vis}, 32'h5);
    chk_slot(0, 7, 3, 1);
    chk_slot(1, 6, 4, 1);
    chk_slot(2, 9, 5, 1);
    chk_slot(3, 8, 6, 1);
    extra = 0;
    repeat (20) @(negedge clk);

    // channel 1 stuck low -> timeout, scan carries on
    hold_low = 4'b0010;
    ch_en = 4'hF;
    repeat (2) @(negedge clk);
    start_scan();
    wait_done(1000, "scan_tmo", vis);
    chk("scan_tmo_visited", {28'd0, vis}, 32'hF);
    chk_slot(0, 5, 3, 1);
    chk_slot(1, 0, 0, 2);
    chk_slot(2, 7, 5, 1);
    chk_slot(3, 8, 6, 1);
    hold_low = '0;
    repeat (20) @(negedge clk);

    // continuous scanning, then CONT dropped mid-scan
    cont = 1'b1;
    start_scan();
    wait_done(600, "cont1", vis);
    chk("cont1_busy", {31'd0, busy}, 32'd1);
    wait_done(600, "cont2", vis);
    chk("cont2_busy", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    cont = 1'b0;
    chk("cont_mid_busy", {31'd0, busy}, 32'd1);
    wait_done(600, "cont3", vis);
    chk("cont3_busy", {31'd0, busy}, 32'd0);
    count_dones(200);
    chk("cont_stopped_dones", 32'(dn), 32'd0);
    chk("cont_stopped_busy", {31'd0, busy}, 32'd0);

    // reset while measuring the low phase of channel 2
    start_scan();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
        @(negedge clk);
        if (busy && ch_sel == 2'd2) hit = 1'b1;
      end
      chk("reach_ch2", {31'd0, hit}, 32'd1);
    end
    repeat (3) @(negedge clk);
    #1;
    wait_tac2(1'b0);
    wait_tac2(1'b1);
    wait_tac2(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_chsel", {30'd0, ch_sel}, 32'd0);
    for (int k = 0; k < 4; k++) chk_slot(k, 0, 0, 0);
    rst = 1'b0;
    ch_en = 4'hF;
    start_scan();
    wait_done(600, "post_rst", vis);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) chk_slot(k, 5 + k, 3 + k, 1);

    // empty mask: immediate DONE, never busy
    ch_en = 4'h0;
    start_scan();
    chk("mask0_done", {31'd0, done}, 32'd1);
    chk("mask0_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("mask0_done_clr", {31'd0, done}, 32'd0);
    chk("mask0_busy_after", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
